// File: rtl/sequence_checker_if.sv
// Symbol-in / status-out bundle between the sequence generator side and sequence_checker.
// Err_Count exists only when SEQ_CHECKER_STATS_EN is defined.
interface sequence_checker_if #(
   parameter int CNT_W = 8
);
   // Handshake: in_sym is consumed on a rising clk edge where in_valid is high;
   // there is no back-pressure, the checker accepts every valid symbol.
   logic             in_valid;
   logic [2:0]       in_sym;
   logic             locked;
   logic             seq_done;
   logic             error;
   logic [CNT_W-1:0] seq_count;
`ifdef SEQ_CHECKER_STATS_EN
   logic [CNT_W-1:0] err_count;

   modport master (
      output in_valid, in_sym,
      input  locked, seq_done, error, seq_count, err_count
   );
   modport slave (
      input  in_valid, in_sym,
      output locked, seq_done, error, seq_count, err_count
   );
`else
   modport master (
      output in_valid, in_sym,
      input  locked, seq_done, error, seq_count
   );
   modport slave (
      input  in_valid, in_sym,
      output locked, seq_done, error, seq_count
   );
`endif
endinterface

// File: rtl/sequence_checker.sv
// Checks the 000->011->010->101->111 symbol cycle, locks after LOCK_SEQS clean sequences.
// Optional saturating error counter enabled by defining SEQ_CHECKER_STATS_EN.
module sequence_checker #(
   parameter int LOCK_SEQS  = 2,
   parameter int MISS_LIMIT = 3,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   sequence_checker_if.slave  bus,
   output logic [1:0]         dbg_state
);

   generate
      if (LOCK_SEQS < 1 || MISS_LIMIT < 1 || CNT_W < 1) begin : g_param_err
         $error("sequence_checker: LOCK_SEQS, MISS_LIMIT and CNT_W must all be >= 1");
      end
   endgenerate

   localparam int GOOD_W = (LOCK_SEQS < 1) ? 1 : $clog2(LOCK_SEQS + 1);
   localparam int MISS_W = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [2:0]         pos, pos_n;
   logic [GOOD_W-1:0]  good, good_n;
   logic [MISS_W-1:0]  miss, miss_n;
   logic               dirty, dirty_n;
   logic               locked_q, locked_n;
   logic               done_q, done_n;
   logic               err_q, err_n;
   logic [CNT_W-1:0]   seq_cnt, seq_cnt_n;
   logic [CNT_W-1:0]   err_cnt, err_cnt_n;

   logic               match;
   logic               last;
   logic [2:0]         pos_adv;
   logic [GOOD_W-1:0]  good_inc;
   logic [MISS_W-1:0]  miss_inc;

   function automatic logic [2:0] expected_sym(input logic [2:0] p);
      logic [2:0] s;
      case (p)
         3'd0:    s = 3'b000;
         3'd1:    s = 3'b011;
         3'd2:    s = 3'b010;
         3'd3:    s = 3'b101;
         default: s = 3'b111;
      endcase
      return s;
   endfunction

   assign match    = (bus.in_sym == expected_sym(pos));
   assign last     = (pos == 3'd4);
   assign pos_adv  = last ? 3'd0 : pos + 3'd1;
   assign good_inc = good + GOOD_W'(1);
   assign miss_inc = miss + MISS_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         pos      <= 3'd0;
         good     <= '0;
         miss     <= '0;
         dirty    <= 1'b0;
         locked_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         seq_cnt  <= '0;
         err_cnt  <= '0;
      end else begin
         state    <= state_n;
         pos      <= pos_n;
         good     <= good_n;
         miss     <= miss_n;
         dirty    <= dirty_n;
         locked_q <= locked_n;
         done_q   <= done_n;
         err_q    <= err_n;
         seq_cnt  <= seq_cnt_n;
         err_cnt  <= err_cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      pos_n     = pos;
      good_n    = good;
      miss_n    = miss;
      dirty_n   = dirty;
      locked_n  = locked_q;
      done_n    = 1'b0;
      err_n     = 1'b0;
      seq_cnt_n = seq_cnt;

      if (bus.in_valid) begin
         case (state)
            HUNT: begin
               // Stale or mid-cycle symbols after start-up are silently skipped here.
               if (bus.in_sym == 3'b000) begin
                  state_n = TRACK;
                  pos_n   = 3'd1;
                  good_n  = '0;
                  miss_n  = '0;
                  dirty_n = 1'b0;
               end
            end
            TRACK: begin
               if (match) begin
                  pos_n = pos_adv;
                  if (last) begin
                     dirty_n = 1'b0;
                     if (!dirty) begin
                        done_n    = 1'b1;
                        seq_cnt_n = seq_cnt + CNT_W'(1);
                        good_n    = good_inc;
                        if (good_inc == GOOD_W'(LOCK_SEQS)) begin
                           state_n  = LOCKED;
                           locked_n = 1'b1;
                        end
                     end
                  end
               end else begin
                  err_n   = 1'b1;
                  good_n  = '0;
                  dirty_n = 1'b0;
                  if (bus.in_sym == 3'b000) begin
                     pos_n = 3'd1;
                  end else begin
                     state_n = HUNT;
                     pos_n   = 3'd0;
                  end
               end
            end
            LOCKED: begin
               if (match) begin
                  pos_n  = pos_adv;
                  miss_n = '0;
                  if (last) begin
                     dirty_n = 1'b0;
                     if (!dirty) begin
                        done_n    = 1'b1;
                        seq_cnt_n = seq_cnt + CNT_W'(1);
                     end
                  end
               end else begin
                  err_n = 1'b1;
                  if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                     state_n  = HUNT;
                     locked_n = 1'b0;
                     pos_n    = 3'd0;
                     good_n   = '0;
                     miss_n   = '0;
                     dirty_n  = 1'b0;
                  end else begin
                     // Flywheel: keep stepping the expected pointer across the bad symbol.
                     miss_n  = miss_inc;
                     pos_n   = pos_adv;
                     dirty_n = !last;
                  end
               end
            end
            default: begin
               state_n  = HUNT;
               pos_n    = 3'd0;
               locked_n = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      err_cnt_n = err_cnt;
`ifdef SEQ_CHECKER_STATS_EN
      if (err_n && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt_n = err_cnt + CNT_W'(1);
      end
`endif
   end

   assign bus.locked    = locked_q;
   assign bus.seq_done  = done_q;
   assign bus.error     = err_q;
   assign bus.seq_count = seq_cnt;
`ifdef SEQ_CHECKER_STATS_EN
   assign bus.err_count = err_cnt;
`endif
   assign dbg_state     = state;

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench for sequence_checker: directed scenarios plus a randomized stream
// compared each cycle against a behavioural model of the checking rules.
module tb_sequence_checker;

   localparam int LOCK_SEQS  = 2;
   localparam int MISS_LIMIT = 3;
   localparam int CNT_W      = 4;
   localparam int OUT_W      = 3 + 2 * CNT_W;
   localparam int CNT_MOD    = 1 << CNT_W;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   sequence_checker_if #(.CNT_W(CNT_W)) bus ();

   sequence_checker #(
      .LOCK_SEQS (LOCK_SEQS),
      .MISS_LIMIT(MISS_LIMIT),
      .CNT_W     (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   logic [CNT_W-1:0] obs_err_cnt;
`ifdef SEQ_CHECKER_STATS_EN
   assign obs_err_cnt = bus.err_count;
`else
   assign obs_err_cnt = '0;
`endif

   logic [OUT_W-1:0] obs_w;
   assign obs_w = {bus.locked, bus.seq_done, bus.error, bus.seq_count, obs_err_cnt};

   int checks = 0;
   int errors = 0;

   logic [OUT_W-1:0] exp_q[$];
   logic [2:0]       exp_tbl[5] = '{3'b000, 3'b011, 3'b010, 3'b101, 3'b111};

   // Reference model: mode 0 = searching, 1 = following, 2 = locked.
   int m_mode, m_pos, m_good, m_miss;
   bit m_dirty, m_done, m_err;
   int m_seq_total, m_err_total;

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_dirty = 0;
      m_done = 0; m_err = 0; m_seq_total = 0; m_err_total = 0;
   endtask

   function automatic logic [OUT_W-1:0] model_word();
      logic [CNT_W-1:0] sc, ec;
      sc = CNT_W'(m_seq_total % CNT_MOD);
      ec = '0;
`ifdef SEQ_CHECKER_STATS_EN
      ec = (m_err_total > CNT_MOD - 1) ? CNT_W'(CNT_MOD - 1) : CNT_W'(m_err_total);
`endif
      return {(m_mode == 2), m_done, m_err, sc, ec};
   endfunction

   task automatic model_step(input bit valid, input logic [2:0] sym);
      m_done = 0;
      m_err  = 0;
      if (!valid) return;
      if (m_mode == 0) begin
         if (sym == 3'b000) begin m_mode = 1; m_pos = 1; m_good = 0; m_dirty = 0; end
      end else if (sym == exp_tbl[m_pos]) begin
         if (m_mode == 2) m_miss = 0;
         if (m_pos == 4) begin
            if (!m_dirty) begin
               m_done = 1;
               m_seq_total++;
               if (m_mode == 1) begin
                  m_good++;
                  if (m_good == LOCK_SEQS) m_mode = 2;
               end
            end
            m_dirty = 0;
            m_pos = 0;
         end else begin
            m_pos++;
         end
      end else begin
         m_err = 1;
         m_err_total++;
         if (m_mode == 1) begin
            m_good = 0;
            m_dirty = 0;
            if (sym == 3'b000) m_pos = 1;
            else begin m_mode = 0; m_pos = 0; end
         end else begin
            m_miss++;
            if (m_miss == MISS_LIMIT) begin
               m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_dirty = 0;
            end else begin
               m_dirty = (m_pos != 4);
               m_pos = (m_pos + 1) % 5;
            end
         end
      end
   endtask

   task automatic drive(input bit valid, input logic [2:0] sym);
      bus.in_valid = valid;
      bus.in_sym   = sym;
      model_step(valid, sym);
      exp_q.push_back(model_word());
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_sym   = 3'b000;
      rst_n = 1'b0;
      model_reset();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.in_sym   = 3'b000;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs_w !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, expected %h", obs_w, {OUT_W{1'b0}});
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d, expected 0", dbg_state);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_clean_lock();
      logic [OUT_W-1:0] exp_w;
      do_reset();
      for (int e = 1; e <= 10; e++) begin
         drive(1'b1, exp_tbl[(e - 1) % 5]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL clean_lock_model edge %0d: got %h, expected %h", e, obs_w, exp_w);
         end
         checks++;
         if (bus.seq_done !== (e == 5 || e == 10)) begin
            errors++;
            $display("FAIL clean_lock_done edge %0d: got %b", e, bus.seq_done);
         end
         checks++;
         if (bus.locked !== (e >= 10)) begin
            errors++;
            $display("FAIL clean_lock_locked edge %0d: got %b", e, bus.locked);
         end
      end
      checks++;
      if (bus.seq_count !== CNT_W'(2)) begin
         errors++;
         $display("FAIL clean_lock_count: got %0d, expected 2", bus.seq_count);
      end
   endtask

   // Runs right after test_clean_lock: locked, pointer at 000.
   task automatic test_flywheel();
      logic [OUT_W-1:0] exp_w;
      logic [2:0]       syms[10] = '{3'b000, 3'b011, 3'b110, 3'b101, 3'b111,
                                      3'b000, 3'b011, 3'b010, 3'b101, 3'b111};
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, syms[i]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL flywheel_model step %0d: got %h, expected %h", i, obs_w, exp_w);
         end
         checks++;
         if (bus.error !== (i == 2) || bus.locked !== 1'b1 || bus.seq_done !== (i == 9)) begin
            errors++;
            $display("FAIL flywheel_flags step %0d: got err=%b lock=%b done=%b", i,
                     bus.error, bus.locked, bus.seq_done);
         end
      end
      checks++;
      if (bus.seq_count !== CNT_W'(3)) begin
         errors++;
         $display("FAIL flywheel_count: got %0d, expected 3", bus.seq_count);
      end
   endtask

   task automatic test_miss_limit();
      logic [OUT_W-1:0] exp_w;
      logic [2:0]       syms[14] = '{3'b000, 3'b001, 3'b001, 3'b001,
                                      3'b000, 3'b011, 3'b010, 3'b101, 3'b111,
                                      3'b000, 3'b011, 3'b010, 3'b101, 3'b111};
      do_reset();
      for (int e = 0; e < 10; e++) begin
         drive(1'b1, exp_tbl[e % 5]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL miss_lock_model edge %0d: got %h, expected %h", e, obs_w, exp_w);
         end
      end
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, syms[i]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL miss_limit_model step %0d: got %h, expected %h", i, obs_w, exp_w);
         end
         checks++;
         if (bus.locked !== (i < 3 || i == 13) || bus.error !== (i >= 1 && i <= 3)) begin
            errors++;
            $display("FAIL miss_limit_flags step %0d: got lock=%b err=%b", i, bus.locked, bus.error);
         end
      end
   endtask

   task automatic test_valid_toggle();
      logic [OUT_W-1:0] exp_w;
      int               n;
      do_reset();
      n = 0;
      for (int c = 0; c < 20; c++) begin
         if (c % 2 == 0) begin
            n++;
            drive(1'b1, exp_tbl[(n - 1) % 5]);
         end else begin
            drive(1'b0, 3'(c));
         end
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL valid_toggle_model cycle %0d: got %h, expected %h", c, obs_w, exp_w);
         end
         checks++;
         if (bus.seq_done !== (c % 2 == 0 && (n == 5 || n == 10)) ||
             bus.locked !== (n >= 10) || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL valid_toggle_flags cycle %0d: got done=%b lock=%b err=%b", c,
                     bus.seq_done, bus.locked, bus.error);
         end
      end
   endtask

   task automatic test_counters();
      logic [OUT_W-1:0] exp_w;
      do_reset();
      for (int e = 0; e < 5 * (CNT_MOD + 1); e++) begin
         drive(1'b1, exp_tbl[e % 5]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL wrap_model edge %0d: got %h, expected %h", e, obs_w, exp_w);
         end
         if (e == 5 * CNT_MOD - 1) begin
            checks++;
            if (bus.seq_count !== '0) begin
               errors++;
               $display("FAIL seq_count_wrap: got %0d, expected 0", bus.seq_count);
            end
         end
      end
      do_reset();
      for (int k = 0; k < CNT_MOD + 4; k++) begin
         drive(1'b1, 3'b000);
         void'(exp_q.pop_front());
         drive(1'b1, 3'b001);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w || bus.error !== 1'b1) begin
            errors++;
            $display("FAIL track_error_model round %0d: got %h, expected %h", k, obs_w, exp_w);
         end
      end
`ifdef SEQ_CHECKER_STATS_EN
      checks++;
      if (bus.err_count !== {CNT_W{1'b1}}) begin
         errors++;
         $display("FAIL err_count_saturate: got %0d, expected %0d", bus.err_count, CNT_MOD - 1);
      end
`endif
   endtask

   task automatic test_reset_async();
      logic [OUT_W-1:0] exp_w;
      do_reset();
      for (int e = 0; e < 10; e++) begin
         drive(1'b1, exp_tbl[e % 5]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL async_lock_model edge %0d: got %h, expected %h", e, obs_w, exp_w);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_w !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs: got %h, expected 0", obs_w);
      end
      model_reset();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [OUT_W-1:0] exp_w;
      int               gen_phase, err_pct;
      bit               v;
      logic [2:0]       s;
      do_reset();
      gen_phase = $urandom_range(0, 4);
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) err_pct = (c / 250 % 3 == 0) ? 2 : ((c / 250 % 3 == 1) ? 15 : 45);
         v = ($urandom_range(0, 99) < 80);
         s = exp_tbl[gen_phase];
         if ($urandom_range(0, 99) < err_pct) s = 3'($urandom_range(0, 7));
         if (v) gen_phase = (gen_phase + 1) % 5;
         drive(v, s);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL random_model cycle %0d: got %h, expected %h", c, obs_w, exp_w);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sym   = 3'b000;
      test_reset();
      test_clean_lock();
      test_flywheel();
      test_miss_limit();
      test_valid_toggle();
      test_counters();
      test_reset_async();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
